// File: rtl/wcoal_pkg.sv
// Shared types for the wide write coalescer: FSM states, lane and group records.
package wcoal_pkg;

  localparam int LANES   = 4;
  // Lane addresses are carried at this width internally; AW must not exceed it.
  localparam int LANE_AW = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [LANE_AW-1:0] addr;
    logic [7:0]         data;
    logic               valid;
  } lane_t;

  typedef struct packed {
    lane_t [LANES-1:0] lane;
  } group_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/wcoal_fifo.sv
// Synchronous FIFO of 4-lane write groups; push while full is accepted only
// when a pop happens in the same cycle. Clear empties it and wins over push/pop.
module wcoal_fifo
  import wcoal_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  group_t wr_entry,
  input  logic   pop,
  output group_t rd_entry,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  group_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/wide_write_coalescer.sv
// Merges each 4-lane byte-write group into 32-bit word writes with byte enables.
// Optional WCOAL_PERF_EN adds accepted word/byte write counters.
module wide_write_coalescer
  import wcoal_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic [AW-1:0] in_waddr0,
  input  logic [AW-1:0] in_waddr1,
  input  logic [AW-1:0] in_waddr2,
  input  logic [AW-1:0] in_waddr3,
  input  logic [7:0]    in_wdata0,
  input  logic [7:0]    in_wdata1,
  input  logic [7:0]    in_wdata2,
  input  logic [7:0]    in_wdata3,
  input  logic          in_we0,
  input  logic          in_we1,
  input  logic          in_we2,
  input  logic          in_we3,
  output logic          o_ready,
  output logic [AW-3:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wbe,
  output logic          mem_we,
  input  logic          mem_wready,
  output logic          o_idle,
  output logic          o_overflow
`ifdef WCOAL_PERF_EN
  ,
  output logic [31:0]   o_word_wr_count,
  output logic [31:0]   o_byte_wr_count
`endif
);

  state_t               state_q, state_d;
  group_t               in_grp;
  group_t               fifo_rd;
  group_t               work_q;
  logic                 any_we;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic                 accept;
  logic [1:0]           lead;
  logic                 lead_found;
  logic [LANE_AW-3:0]   word;
  logic [3:0]           pending;
  logic [3:0]           merge_mask;
  logic [3:0]           merge_be;
  logic [31:0]          merge_data;
  logic [3:0]           remaining;

  always_comb begin
    in_grp = '0;
    in_grp.lane[0] = '{addr: LANE_AW'(in_waddr0), data: in_wdata0, valid: in_we0};
    in_grp.lane[1] = '{addr: LANE_AW'(in_waddr1), data: in_wdata1, valid: in_we1};
    in_grp.lane[2] = '{addr: LANE_AW'(in_waddr2), data: in_wdata2, valid: in_we2};
    in_grp.lane[3] = '{addr: LANE_AW'(in_waddr3), data: in_wdata3, valid: in_we3};
  end

  assign any_we = in_we0 | in_we1 | in_we2 | in_we3;

  wcoal_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (i_clear),
    .push     (any_we),
    .wr_entry (in_grp),
    .pop      (fifo_pop),
    .rd_entry (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Lowest pending lane picks the word; ascending scan lets the higher lane win a byte collision.
  always_comb begin
    pending    = '0;
    lead       = '0;
    lead_found = 1'b0;
    merge_mask = '0;
    merge_be   = '0;
    merge_data = '0;
    for (int i = 0; i < LANES; i++) begin
      pending[i] = work_q.lane[i].valid;
      if (!lead_found && work_q.lane[i].valid) begin
        lead       = 2'(i);
        lead_found = 1'b1;
      end
    end
    word = work_q.lane[lead].addr[LANE_AW-1:2];
    for (int i = 0; i < LANES; i++) begin
      if (work_q.lane[i].valid && (work_q.lane[i].addr[LANE_AW-1:2] == word)) begin
        merge_mask[i]                                   = 1'b1;
        merge_be[work_q.lane[i].addr[1:0]]              = 1'b1;
        merge_data[{work_q.lane[i].addr[1:0], 3'b000} +: 8] = work_q.lane[i].data;
      end
    end
    remaining = pending & ~merge_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) state_d = S_EMIT;
        S_EMIT: if (accept && remaining == '0 && fifo_empty) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = (state_q == S_EMIT);
    mem_waddr = mem_we ? word[AW-3:0] : '0;
    mem_wdata = mem_we ? merge_data : '0;
    mem_wbe   = mem_we ? merge_be : '0;
    accept    = mem_we && mem_wready;
    fifo_pop  = !i_clear && !fifo_empty &&
                ((state_q == S_IDLE) || (accept && remaining == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
    end else if (i_clear) begin
      work_q <= '0;
    end else if (fifo_pop) begin
      work_q <= fifo_rd;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) work_q.lane[i].valid <= remaining[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 o_overflow <= 1'b0;
    else if (i_clear)                           o_overflow <= 1'b0;
    else if (any_we && fifo_full && !fifo_pop)  o_overflow <= 1'b1;
  end

  assign o_ready = !fifo_full;
  assign o_idle  = fifo_empty && (state_q == S_IDLE);

`ifdef WCOAL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_word_wr_count <= '0;
      o_byte_wr_count <= '0;
    end else if (i_clear) begin
      o_word_wr_count <= '0;
      o_byte_wr_count <= '0;
    end else if (accept) begin
      o_word_wr_count <= o_word_wr_count + 32'd1;
      o_byte_wr_count <= o_byte_wr_count + 32'(popcount4(mem_wbe));
    end
  end
`endif

endmodule

// File: tb/tb_wide_write_coalescer.sv
// Directed bench for wide_write_coalescer with an expected-write scoreboard.
module tb_wide_write_coalescer;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-3:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    wbe;
  } wr_t;

  logic          clk, rst_n, i_clear;
  logic [AW-1:0] in_waddr0, in_waddr1, in_waddr2, in_waddr3;
  logic [7:0]    in_wdata0, in_wdata1, in_wdata2, in_wdata3;
  logic          in_we0, in_we1, in_we2, in_we3;
  logic          o_ready, mem_we, mem_wready, o_idle, o_overflow;
  logic [AW-3:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wbe;
`ifdef WCOAL_PERF_EN
  logic [31:0]   o_word_wr_count, o_byte_wr_count;
`endif

  wide_write_coalescer #(.AW(AW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
    .in_waddr0(in_waddr0), .in_waddr1(in_waddr1), .in_waddr2(in_waddr2), .in_waddr3(in_waddr3),
    .in_wdata0(in_wdata0), .in_wdata1(in_wdata1), .in_wdata2(in_wdata2), .in_wdata3(in_wdata3),
    .in_we0(in_we0), .in_we1(in_we1), .in_we2(in_we2), .in_we3(in_we3),
    .o_ready(o_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
    .mem_we(mem_we), .mem_wready(mem_wready), .o_idle(o_idle), .o_overflow(o_overflow)
`ifdef WCOAL_PERF_EN
    , .o_word_wr_count(o_word_wr_count), .o_byte_wr_count(o_byte_wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  wr_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grp(input logic [3:0] we,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_waddr0 = a0; in_waddr1 = a1; in_waddr2 = a2; in_waddr3 = a3;
    in_wdata0 = d0; in_wdata1 = d1; in_wdata2 = d2; in_wdata3 = d3;
    {in_we3, in_we2, in_we1, in_we0} = we;
    step();
    {in_we3, in_we2, in_we1, in_we0} = 4'b0000;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      done = o_idle && (sb.size() == 0);
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // Every accepted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_wready) begin
      wr_t e;
      check("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_waddr", 64'(mem_waddr), 64'(e.waddr));
        check("wr_wdata", 64'(mem_wdata), 64'(e.wdata));
        check("wr_wbe",   64'(mem_wbe),   64'(e.wbe));
      end
    end
  end

  initial begin
    logic [AW-3:0] cap_waddr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wbe;
    logic [7:0]    d [4];

    rst_n = 1'b0; i_clear = 1'b0; mem_wready = 1'b1;
    in_waddr0 = '0; in_waddr1 = '0; in_waddr2 = '0; in_waddr3 = '0;
    in_wdata0 = '0; in_wdata1 = '0; in_wdata2 = '0; in_wdata3 = '0;
    {in_we3, in_we2, in_we1, in_we0} = 4'b0000;
    #1;
    check("rst_mem_we",    64'(mem_we),     64'd0);
    check("rst_mem_waddr", 64'(mem_waddr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata),  64'd0);
    check("rst_mem_wbe",   64'(mem_wbe),    64'd0);
    check("rst_ready",     64'(o_ready),    64'd1);
    check("rst_idle",      64'(o_idle),     64'd1);
    check("rst_overflow",  64'(o_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Aligned group: single full-word write, mem_we only in cycle 2.
    sb.push_back('{waddr: 8'h10, wdata: 32'h44332211, wbe: 4'hF});
    push_grp(4'b1111, 10'h40, 10'h41, 10'h42, 10'h43, 8'h11, 8'h22, 8'h33, 8'h44);
    check("al_we_c1", 64'(mem_we), 64'd0);
    step();
    check("al_we_c2", 64'(mem_we), 64'd1);
    step();
    check("al_we_c3", 64'(mem_we), 64'd0);
    wait_drain("al_drain");

    // Unaligned group straddles two words.
    sb.push_back('{waddr: 8'h10, wdata: 32'hA1A00000, wbe: 4'b1100});
    sb.push_back('{waddr: 8'h11, wdata: 32'h0000A3A2, wbe: 4'b0011});
    push_grp(4'b1111, 10'h42, 10'h43, 10'h44, 10'h45, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    wait_drain("ua_drain");
`ifdef WCOAL_PERF_EN
    check("perf_words", 64'(o_word_wr_count), 64'd3);
    check("perf_bytes", 64'(o_byte_wr_count), 64'd8);
`endif

    // Partial enables with a byte collision: lane 3 overrides lane 1.
    sb.push_back('{waddr: 8'h02, wdata: 32'h00000077, wbe: 4'b0001});
    push_grp(4'b1010, 10'h3FF, 10'h008, 10'h1FE, 10'h008, 8'hEE, 8'h55, 8'hDD, 8'h77);
    wait_drain("col_drain");

    // Backpressure: the first group moves into the working entry, the next four
    // fill the FIFO, and the sixth is dropped.
    mem_wready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'(16 * k + i + 1);
      if (k < 5)
        sb.push_back('{waddr: 8'(8'h40 + k), wdata: {d[3], d[2], d[1], d[0]}, wbe: 4'hF});
      push_grp(4'b1111, 10'(10'h100 + 4*k), 10'(10'h101 + 4*k), 10'(10'h102 + 4*k),
               10'(10'h103 + 4*k), d[0], d[1], d[2], d[3]);
      if (k == 4) begin
        check("bp_ready_full", 64'(o_ready),    64'd0);
        check("bp_ovf_before", 64'(o_overflow), 64'd0);
      end
    end
    check("bp_ovf_after", 64'(o_overflow), 64'd1);
    cap_waddr = mem_waddr; cap_wdata = mem_wdata; cap_wbe = mem_wbe;
    check("bp_head_waddr", 64'(cap_waddr), 64'h40);
    for (int n = 0; n < 8; n++) begin
      step();
      check("bp_hold_we",    64'(mem_we),    64'd1);
      check("bp_hold_waddr", 64'(mem_waddr), 64'(cap_waddr));
      check("bp_hold_wdata", 64'(mem_wdata), 64'(cap_wdata));
      check("bp_hold_wbe",   64'(mem_wbe),   64'(cap_wbe));
    end
    mem_wready = 1'b1;
    wait_drain("bp_drain");

    // Clear while emitting with two groups queued; none of them may be written.
    mem_wready = 1'b0;
    for (int k = 0; k < 3; k++)
      push_grp(4'b1111, 10'(10'h200 + 4*k), 10'(10'h201 + 4*k), 10'(10'h202 + 4*k),
               10'(10'h203 + 4*k), 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    check("clr_pre_we",   64'(mem_we), 64'd1);
    check("clr_pre_idle", 64'(o_idle), 64'd0);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clr_we",       64'(mem_we),     64'd0);
    check("clr_idle",     64'(o_idle),     64'd1);
    check("clr_overflow", 64'(o_overflow), 64'd0);
    check("clr_ready",    64'(o_ready),    64'd1);
`ifdef WCOAL_PERF_EN
    check("clr_perf_words", 64'(o_word_wr_count), 64'd0);
    check("clr_perf_bytes", 64'(o_byte_wr_count), 64'd0);
`endif
    mem_wready = 1'b1;
    repeat (5) step();
    check("clr_still_idle", 64'(o_idle), 64'd1);

    // Async reset while a write is pending drops mem_we without a clock edge.
    mem_wready = 1'b0;
    push_grp(4'b0001, 10'h300, 10'h0, 10'h0, 10'h0, 8'h5A, 8'h0, 8'h0, 8'h0);
    step();
    check("ar_pre_we", 64'(mem_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we",   64'(mem_we), 64'd0);
    check("ar_idle", 64'(o_idle), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_wready = 1'b1;
    repeat (4) step();
    check("ar_post_we", 64'(mem_we), 64'd0);
    check("sb_empty",   64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
